// File: rtl/pipe_tx_mux_buffer_if.sv
// rtl/pipe_tx_mux_buffer_if.sv - channel-input / host-pipe bundle for pipe_tx_mux_buffer
// Purpose: groups the per-channel sample inputs, control strobes and host
//   pipe-out results so the buffer and its driver share one port list.
// Modports:
//   slave  - buffer side: samples/controls in, block word/status out
//   master - driver side: samples/controls out, block word/status in
interface pipe_tx_mux_buffer_if #(
  parameter int N_CHAN = 8,
  parameter int W_DATA = 16,
  parameter int DEPTH  = 2048
);
  localparam int TAG_W = $clog2(N_CHAN);
  localparam int FW    = $clog2(DEPTH) + 1;

  logic [N_CHAN-1:0]        data_valid_in;
  logic [N_CHAN*W_DATA-1:0] data_in;
  logic [N_CHAN-1:0]        chan_en_in;
  logic                     mode_in;
  logic                     flush_in;
  logic                     ovf_clr_in;
  logic                     pipe_read_in;
  logic [W_DATA-1:0]        data_out;
  logic [TAG_W-1:0]         tag_out;
  logic                     block_ready_out;
  logic [FW-1:0]            fill_out;
  logic [15:0]              ovf_count_out;

  modport slave (
    input  data_valid_in, data_in, chan_en_in, mode_in, flush_in, ovf_clr_in, pipe_read_in,
    output data_out, tag_out, block_ready_out, fill_out, ovf_count_out
  );

  modport master (
    output data_valid_in, data_in, chan_en_in, mode_in, flush_in, ovf_clr_in, pipe_read_in,
    input  data_out, tag_out, block_ready_out, fill_out, ovf_count_out
  );
endinterface

// File: rtl/pipe_tx_mux_buffer.sv
// rtl/pipe_tx_mux_buffer.sv - N-channel round-robin merge into a tagged circular pipe-out buffer
// Purpose: each channel holds one pending sample; a round-robin arbiter moves at
//   most one {tag, sample} per cycle into a DEPTH-word ring. The host drains
//   READ_LEN-word blocks with pipe_read_in; words appear one cycle after the strobe.
// Ports:
//   clk_in  - single clock for samples and host pipe
//   rst_in  - asynchronous active-high reset
//   bus     - pipe_tx_mux_buffer_if.slave (samples, enables, mode, flush,
//             ovf clear, read strobe / block word, tag, ready, fill, ovf count)
module pipe_tx_mux_buffer #(
  parameter int N_CHAN   = 8,
  parameter int W_DATA   = 16,
  parameter int DEPTH    = 2048,
  parameter int READ_LEN = 1024
) (
  input  logic                clk_in,
  input  logic                rst_in,
  pipe_tx_mux_buffer_if.slave bus
);
  localparam int TAG_W = $clog2(N_CHAN);
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = AW + 1;
  localparam int CW    = $clog2(READ_LEN + 1);

  typedef enum logic {ST_WAIT, ST_READ} state_t;

  state_t                    state_q;
  logic [CW-1:0]             rd_count_q;
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]             fill_q, fill_d;
  logic [15:0]               ovf_q, ovf_d;
  logic [N_CHAN-1:0]         pending_q;
  logic [W_DATA-1:0]         hold_q [N_CHAN];
  logic [TAG_W-1:0]          last_grant_q;
  logic [W_DATA-1:0]         data_q;
  logic [TAG_W-1:0]          tag_q;
  logic [TAG_W+W_DATA-1:0]   mem [DEPTH];

  logic [N_CHAN-1:0]         req, gnt_oh;
  logic [2*N_CHAN-1:0]       rot;
  logic [TAG_W-1:0]          start, grant_idx;
  logic [TAG_W:0]            sum;
  logic                      grant_vld, full, block_ready, rd_fire;
  logic                      wr_en, wr_drop, wr_ovwr, cap_drop;

  // Round-robin: rotate the request vector so bit 0 is last_grant+1, pick the
  // lowest set bit, then map the offset back to a channel number.
  always_comb begin
    req   = pending_q & bus.chan_en_in;
    start = (last_grant_q == TAG_W'(N_CHAN - 1)) ? '0 : last_grant_q + 1'b1;
    rot   = {req, req} >> start;
    sum   = '0;
    for (int k = N_CHAN - 1; k >= 0; k--) begin
      if (rot[k]) sum = {1'b0, start} + (TAG_W+1)'(k);
    end
    grant_vld = |req;
    grant_idx = (sum >= (TAG_W+1)'(N_CHAN)) ? TAG_W'(sum - (TAG_W+1)'(N_CHAN)) : sum[TAG_W-1:0];
    gnt_oh    = grant_vld ? (N_CHAN'(1) << grant_idx) : '0;
  end

  always_comb begin
    full        = (fill_q == FW'(DEPTH));
    block_ready = (state_q == ST_WAIT) && (fill_q >= FW'(READ_LEN));
    rd_fire     = bus.pipe_read_in && ((state_q == ST_READ) || block_ready);
    // A full ring only overwrites its oldest word in stream mode while no block
    // is in progress and the host is not reading; otherwise the new word is lost.
    wr_drop     = grant_vld && full && (bus.mode_in || (state_q == ST_READ));
    wr_ovwr     = grant_vld && full && !bus.mode_in && (state_q == ST_WAIT) && !rd_fire;
    wr_en       = grant_vld && !wr_drop;
    cap_drop    = |(bus.data_valid_in & bus.chan_en_in & pending_q & ~gnt_oh);

    fill_d = fill_q;
    if (wr_en && !wr_ovwr && !rd_fire) fill_d = fill_q + 1'b1;
    else if (rd_fire && !wr_en)        fill_d = fill_q - 1'b1;

    // Several coincident drops still count once; clear beats increment.
    ovf_d = ovf_q;
    if (bus.ovf_clr_in) ovf_d = '0;
    else if (!bus.flush_in && (wr_drop || wr_ovwr || cap_drop) && (ovf_q != 16'hFFFF))
      ovf_d = ovf_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (wr_en && !bus.flush_in && !rst_in) mem[wr_ptr_q] <= {grant_idx, hold_q[grant_idx]};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_WAIT;
      rd_count_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      ovf_q        <= '0;
      pending_q    <= '0;
      last_grant_q <= '0;
      data_q       <= '0;
      tag_q        <= '0;
      for (int i = 0; i < N_CHAN; i++) hold_q[i] <= '0;
    end else begin
      ovf_q <= ovf_d;
      if (bus.flush_in) begin
        state_q      <= ST_WAIT;
        rd_count_q   <= '0;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        fill_q       <= '0;
        pending_q    <= '0;
        last_grant_q <= '0;
        data_q       <= '0;
        tag_q        <= '0;
        for (int i = 0; i < N_CHAN; i++) hold_q[i] <= '0;
      end else begin
        // A granted channel frees its hold this cycle, so a same-cycle sample is kept.
        for (int i = 0; i < N_CHAN; i++) begin
          if (!bus.chan_en_in[i]) begin
            pending_q[i] <= 1'b0;
          end else if (bus.data_valid_in[i] && (!pending_q[i] || gnt_oh[i])) begin
            hold_q[i]    <= bus.data_in[i*W_DATA +: W_DATA];
            pending_q[i] <= 1'b1;
          end else if (gnt_oh[i]) begin
            pending_q[i] <= 1'b0;
          end
        end
        if (grant_vld)           last_grant_q <= grant_idx;
        if (wr_en)               wr_ptr_q     <= wr_ptr_q + 1'b1;
        if (rd_fire || wr_ovwr)  rd_ptr_q     <= rd_ptr_q + 1'b1;
        fill_q <= fill_d;
        if (rd_fire) begin
          {tag_q, data_q} <= mem[rd_ptr_q];
          case (state_q)
            ST_WAIT: begin
              state_q    <= ST_READ;
              rd_count_q <= CW'(1);
            end
            ST_READ: begin
              if (rd_count_q == CW'(READ_LEN - 1)) begin
                state_q    <= ST_WAIT;
                rd_count_q <= '0;
              end else begin
                rd_count_q <= rd_count_q + 1'b1;
              end
            end
            default: state_q <= ST_WAIT;
          endcase
        end
      end
    end
  end

  assign bus.data_out        = data_q;
  assign bus.tag_out         = tag_q;
  assign bus.block_ready_out = block_ready;
  assign bus.fill_out        = fill_q;
  assign bus.ovf_count_out   = ovf_q;
endmodule

// File: tb/tb_pipe_tx_mux_buffer.sv
// tb/tb_pipe_tx_mux_buffer.sv - self-checking bench for pipe_tx_mux_buffer
module tb_pipe_tx_mux_buffer;
  localparam int N_CHAN   = 8;
  localparam int W_DATA   = 16;
  localparam int DEPTH    = 2048;
  localparam int READ_LEN = 1024;
  localparam int TAG_W    = 3;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [W_DATA-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_tx_mux_buffer_if #(.N_CHAN(N_CHAN), .W_DATA(W_DATA), .DEPTH(DEPTH)) bus ();

  pipe_tx_mux_buffer #(.N_CHAN(N_CHAN), .W_DATA(W_DATA), .DEPTH(DEPTH), .READ_LEN(READ_LEN)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: ring as a queue of tagged words, one hold slot per channel.
  word_t       mq[$];
  logic [W_DATA-1:0] m_hold [N_CHAN];
  bit          m_pend [N_CHAN];
  int          m_last;
  bit          m_reading;
  int          m_cnt;
  word_t       m_out;
  int          m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < N_CHAN; i++) begin m_hold[i] = '0; m_pend[i] = 0; end
    m_last = 0; m_reading = 0; m_cnt = 0; m_out = '0;
  endtask

  task automatic model_step();
    bit ready, rd, was_reading, full, drop;
    int g;
    word_t w;
    if (rst) begin model_clear(); m_ovf = 0; return; end
    if (bus.flush_in) begin model_clear(); if (bus.ovf_clr_in) m_ovf = 0; return; end
    ready       = !m_reading && (mq.size() >= READ_LEN);
    rd          = bus.pipe_read_in && (m_reading || ready);
    was_reading = m_reading;
    full        = (mq.size() == DEPTH);
    drop        = 0;
    g = -1;
    for (int k = 1; k <= N_CHAN; k++) begin
      int c;
      c = (m_last + k) % N_CHAN;
      if (g < 0 && m_pend[c] && bus.chan_en_in[c]) g = c;
    end
    if (rd && mq.size() > 0) begin
      m_out = mq.pop_front();
      if (!m_reading) begin m_reading = 1; m_cnt = 1; end
      else if (m_cnt == READ_LEN - 1) begin m_reading = 0; m_cnt = 0; end
      else m_cnt++;
    end
    if (g >= 0) begin
      w.tag  = TAG_W'(g);
      w.data = m_hold[g];
      if (full && (bus.mode_in || was_reading)) drop = 1;
      else if (full && !rd) begin void'(mq.pop_front()); mq.push_back(w); drop = 1; end
      else mq.push_back(w);
      m_last = g;
    end
    for (int i = 0; i < N_CHAN; i++) begin
      if (!bus.chan_en_in[i]) m_pend[i] = 0;
      else if (bus.data_valid_in[i]) begin
        if (!m_pend[i] || i == g) begin
          m_hold[i] = bus.data_in[i*W_DATA +: W_DATA];
          m_pend[i] = 1;
        end else drop = 1;
      end else if (i == g) m_pend[i] = 0;
    end
    if (bus.ovf_clr_in) m_ovf = 0;
    else if (drop && m_ovf < 65535) m_ovf++;
  endtask

  always @(negedge clk) begin
    chk("data_out", 32'(bus.data_out), 32'(m_out.data));
    chk("tag_out", 32'(bus.tag_out), 32'(m_out.tag));
    chk("block_ready", 32'(bus.block_ready_out), 32'(!m_reading && mq.size() >= READ_LEN));
    chk("fill", 32'(bus.fill_out), 32'(mq.size()));
    chk("ovf", 32'(bus.ovf_count_out), 32'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic fill_ch1(input bit mode);
    bus.flush_in = 1; bus.ovf_clr_in = 1; bus.mode_in = mode;
    tick();
    bus.flush_in = 0; bus.ovf_clr_in = 0;
    bus.chan_en_in = 8'b0000_0010;
    for (int v = 0; v <= 2048; v++) begin
      bus.data_valid_in = 8'b0000_0010;
      bus.data_in = '0;
      bus.data_in[1*W_DATA +: W_DATA] = W_DATA'(v);
      tick();
    end
    bus.data_valid_in = '0;
    tick();
  endtask

  initial begin
    bus.data_valid_in = '0; bus.data_in = '0; bus.chan_en_in = '0;
    bus.mode_in = 0; bus.flush_in = 0; bus.ovf_clr_in = 0; bus.pipe_read_in = 0;
    model_clear(); m_ovf = 0;
    repeat (2) tick();
    rst = 0;
    chk("reset_fill", 32'(bus.fill_out), 0);
    chk("reset_ovf", 32'(bus.ovf_count_out), 0);
    chk("reset_ready", 32'(bus.block_ready_out), 0);
    chk("reset_data", 32'(bus.data_out), 0);

    // ch0 and ch3 every cycle; ch2 strobes while disabled and must be ignored.
    bus.chan_en_in = 8'b0000_1001;
    for (int k = 1; k <= 1023; k++) begin
      bus.data_valid_in = 8'b0000_1101;
      bus.data_in = '0;
      bus.data_in[0*W_DATA +: W_DATA] = W_DATA'(16'h1000 + k);
      bus.data_in[2*W_DATA +: W_DATA] = W_DATA'(16'h2000 + k);
      bus.data_in[3*W_DATA +: W_DATA] = W_DATA'(16'h3000 + k);
      tick();
    end
    bus.data_valid_in = '0;
    repeat (2) tick();
    chk("merge_fill", 32'(bus.fill_out), 1024);
    chk("merge_ovf", 32'(bus.ovf_count_out), 1022);
    chk("merge_ready", 32'(bus.block_ready_out), 1);
    for (int r = 0; r < READ_LEN; r++) begin
      bus.pipe_read_in = 1;
      tick();
      if (r == 0) begin
        chk("first_tag", 32'(bus.tag_out), 3);
        chk("first_data", 32'(bus.data_out), 32'h3001);
        chk("ready_in_read", 32'(bus.block_ready_out), 0);
      end
      if (r == 1) begin
        chk("second_tag", 32'(bus.tag_out), 0);
        chk("second_data", 32'(bus.data_out), 32'h1001);
      end
    end
    bus.pipe_read_in = 1;
    tick();
    bus.pipe_read_in = 0;
    tick();
    chk("drain_fill", 32'(bus.fill_out), 0);
    chk("drain_ready", 32'(bus.block_ready_out), 0);

    // Stream mode: 2049 words overwrite the oldest.
    fill_ch1(1'b0);
    chk("m0_fill", 32'(bus.fill_out), 2048);
    chk("m0_ovf", 32'(bus.ovf_count_out), 1);
    for (int r = 0; r < 500; r++) begin
      bus.pipe_read_in = 1;
      tick();
      if (r == 0) begin
        chk("m0_first", 32'(bus.data_out), 1);
        chk("m0_first_tag", 32'(bus.tag_out), 1);
      end
    end
    bus.pipe_read_in = 0;
    bus.flush_in = 1;
    tick();
    bus.flush_in = 0;
    chk("flush_fill", 32'(bus.fill_out), 0);
    chk("flush_ready", 32'(bus.block_ready_out), 0);
    chk("flush_ovf", 32'(bus.ovf_count_out), 1);

    // Capture mode: the newest word is dropped.
    fill_ch1(1'b1);
    chk("m1_fill", 32'(bus.fill_out), 2048);
    chk("m1_ovf", 32'(bus.ovf_count_out), 1);
    for (int r = 0; r < 2 * READ_LEN; r++) begin
      bus.pipe_read_in = 1;
      tick();
      if (r == 0) chk("m1_first", 32'(bus.data_out), 0);
      if (r == 2 * READ_LEN - 1) chk("m1_last", 32'(bus.data_out), 2047);
    end
    bus.pipe_read_in = 0;
    tick();

    // Asynchronous reset in the middle of a write burst.
    bus.chan_en_in = 8'b0010_0000;
    for (int k = 1; k <= 20; k++) begin
      bus.data_valid_in = 8'b0010_0000;
      bus.data_in = '0;
      bus.data_in[5*W_DATA +: W_DATA] = W_DATA'(16'h5000 + k);
      tick();
    end
    #2;
    rst = 1;
    model_clear(); m_ovf = 0;
    #1;
    chk("arst_fill", 32'(bus.fill_out), 0);
    chk("arst_ovf", 32'(bus.ovf_count_out), 0);
    chk("arst_data", 32'(bus.data_out), 0);
    chk("arst_ready", 32'(bus.block_ready_out), 0);
    bus.data_valid_in = '0;
    tick();
    rst = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
